// File: rtl/elbeth_mem_pkg.sv
// Shared definitions for the ELBETH memory arbiter.
// Holds the arbitration-mode constants, the byte-enable width helper and the
// read-return tag carried alongside each memory access.
package elbeth_mem_pkg;

    localparam int unsigned ARB_RR      = 0;
    localparam int unsigned ARB_FIXED   = 1;
    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned IDX_W       = $clog2(MAX_MASTERS);

    // Read-return tag: valid marks a read, idx names the master to answer
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Number of byte lanes in a data word
    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/elbeth_rr_arbiter.sv
// Combinational request arbiter.
// Round-robin: search starts at i_ptr and wraps modulo N_MASTERS.
// Fixed priority (i_mode_fixed=1): lowest index wins, i_ptr ignored.
// Ports:
//   i_req        per-master request
//   i_ptr        round-robin start index
//   i_mode_fixed 1 = fixed priority, 0 = round-robin
//   o_gnt_c      one-hot grant (zero when no request)
//   o_idx_c      encoded index of the granted master
module elbeth_rr_arbiter
    import elbeth_mem_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    input  logic                 i_mode_fixed,
    output logic [N_MASTERS-1:0] o_gnt_c,
    output logic [IDX_W-1:0]     o_idx_c
);

    logic              w_found;
    logic [31:0]       w_cand;

    // Walk candidates in priority order; the first requesting one wins
    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            w_cand = i_mode_fixed ? 32'(k) : (32'(i_ptr) + 32'(k));
            if (w_cand >= 32'(N_MASTERS)) begin
                w_cand = w_cand - 32'(N_MASTERS);
            end
            for (int unsigned j = 0; j < N_MASTERS; j++) begin
                if (!w_found && (w_cand == 32'(j)) && i_req[j]) begin
                    w_found    = 1'b1;
                    o_gnt_c[j] = 1'b1;
                    o_idx_c    = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// N-master to single-port memory arbiter for the ELBETH memory subsystem.
// One transfer is accepted per cycle (req & gnt at a rising edge); the
// accepted command is registered onto the mem_* port and reads are answered
// through a tag pipeline that raises the requester's rvalid bit RD_LAT cycles
// after its mem_en cycle.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req/we/addr/wdata          per-master request and payload (flattened)
//   gnt                        combinational one-hot grant
//   rvalid/rdata               per-master read valid, shared read data
//   mem_en/mem_we/mem_addr/mem_din  registered RAM command
//   mem_dout                   RAM read data
module elbeth_mem_arbiter
    import elbeth_mem_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned ARB_MODE  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_MASTERS-1:0]             req,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]  we,
    input  logic [N_MASTERS*ADDR_W-1:0]      addr,
    input  logic [N_MASTERS*DATA_W-1:0]      wdata,
    output logic [N_MASTERS-1:0]             gnt,
    output logic [N_MASTERS-1:0]             rvalid,
    output logic [DATA_W-1:0]                rdata,
    output logic                             mem_en,
    output logic [DATA_W/8-1:0]              mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_din,
    input  logic [DATA_W-1:0]                mem_dout
);

    localparam int unsigned BE_W = be_width(DATA_W);

    logic [N_MASTERS-1:0] w_gnt;
    logic [IDX_W-1:0]     w_idx;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic                 w_accept;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [BE_W-1:0]      w_sel_we;
    tag_t                 r_tag [0:RD_LAT];

    elbeth_rr_arbiter #(
        .N_MASTERS (N_MASTERS)
    ) u_arb (
        .i_req        (req),
        .i_ptr        (r_ptr),
        .i_mode_fixed (ARB_MODE == ARB_FIXED),
        .o_gnt_c      (w_gnt),
        .o_idx_c      (w_idx)
    );

    // No grant may be visible while reset is asserted
    assign gnt      = rst ? w_gnt : '0;
    assign w_accept = |gnt;

    // Select the granted master's payload
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (gnt[i]) begin
                w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata[i*DATA_W +: DATA_W];
                w_sel_we    = we[i*BE_W +: BE_W];
            end
        end
    end

    // Round-robin pointer moves past the accepted master, holds when idle
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_accept && (ARB_MODE == ARB_RR)) begin
            if ((32'(w_idx) + 32'd1) >= 32'(N_MASTERS)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = w_idx + IDX_W'(1);
            end
        end
    end

    // Command register: address/data hold when idle, enables drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            mem_en   <= 1'b0;
            mem_we   <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            mem_en <= w_accept;
            if (w_accept) begin
                mem_we   <= w_sel_we;
                mem_addr <= w_sel_addr;
                mem_din  <= w_sel_wdata;
            end else begin
                mem_we   <= '0;
            end
        end
    end

    // Tag pipeline: stage 0 lines up with mem_en, stage RD_LAT with mem_dout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k <= RD_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= tag_t'{valid: (w_accept && (w_sel_we == '0)), idx: w_idx};
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Decode the returning tag into the per-master valid pulse
    always_comb begin
        rvalid = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            rvalid[i] = r_tag[RD_LAT].valid && (r_tag[RD_LAT].idx == IDX_W'(i));
        end
    end

    assign rdata = mem_dout;

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Bench for elbeth_mem_arbiter: two instances (round-robin RD_LAT=2 and
// fixed-priority RD_LAT=4, both with three masters) each driving a
// behavioural write-first RAM.
module tb_elbeth_mem_arbiter;

    typedef struct {
        int          d;
        logic [2:0]  eg;
        logic [31:0] ed;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  req_v      [2];
    logic [11:0] we_v       [2];
    logic [95:0] addr_v     [2];
    logic [95:0] wdata_v    [2];
    logic [2:0]  gnt_v      [2];
    logic [2:0]  rvalid_v   [2];
    logic [31:0] rdata_v    [2];
    logic        mem_en_v   [2];
    logic [3:0]  mem_we_v   [2];
    logic [31:0] mem_addr_v [2];
    logic [31:0] mem_din_v  [2];
    logic [31:0] mem_dout_v [2];

    logic [31:0] ram  [2][256];
    logic [31:0] pipe [2][4];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    elbeth_mem_arbiter #(
        .N_MASTERS(3), .ADDR_W(32), .DATA_W(32), .RD_LAT(2), .ARB_MODE(0)
    ) u_dut_rr (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .gnt(gnt_v[0]), .rvalid(rvalid_v[0]), .rdata(rdata_v[0]),
        .mem_en(mem_en_v[0]), .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]),
        .mem_din(mem_din_v[0]), .mem_dout(mem_dout_v[0])
    );

    elbeth_mem_arbiter #(
        .N_MASTERS(3), .ADDR_W(32), .DATA_W(32), .RD_LAT(4), .ARB_MODE(1)
    ) u_dut_fp (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .gnt(gnt_v[1]), .rvalid(rvalid_v[1]), .rdata(rdata_v[1]),
        .mem_en(mem_en_v[1]), .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]),
        .mem_din(mem_din_v[1]), .mem_dout(mem_dout_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = din[b*8 +: 8];
        end
        return r;
    endfunction

    // Write-first RAM with an RD_LAT-deep read pipe per instance
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_en_v[d]) begin
                ram[d][mem_addr_v[d][7:0]] <= merge(ram[d][mem_addr_v[d][7:0]], mem_din_v[d], mem_we_v[d]);
                pipe[d][0] <= merge(ram[d][mem_addr_v[d][7:0]], mem_din_v[d], mem_we_v[d]);
            end else begin
                pipe[d][0] <= 32'h0;
            end
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
        end
    end

    assign mem_dout_v[0] = pipe[0][1];
    assign mem_dout_v[1] = pipe[1][3];

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h (cycle %0d)", name, d, got, exp, cyc);
        end
    endtask

    task automatic set_m(input int d, input int m, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
        we_v[d][m*4 +: 4]      = be;
        addr_v[d][m*32 +: 32]  = a;
        wdata_v[d][m*32 +: 32] = wd;
    endtask

    // One cycle: drive req at negedge, check grant, then check the issued command
    task automatic step(input int d, input logic [2:0] r, input logic [2:0] eg, input logic [31:0] ed);
        int         gi;
        logic [3:0] ewe;
        req_v[d] = r;
        #4;
        chk("gnt", d, 32'(gnt_v[d]), 32'(eg));
        @(posedge clk);
        #1;
        chk("mem_en", d, 32'(mem_en_v[d]), 32'(eg != 3'b000));
        if (eg != 3'b000) begin
            gi  = eg[0] ? 0 : (eg[1] ? 1 : 2);
            ewe = we_v[d][gi*4 +: 4];
            chk("mem_we", d, 32'(mem_we_v[d]), 32'(ewe));
            chk("mem_addr", d, mem_addr_v[d], addr_v[d][gi*32 +: 32]);
            chk("mem_din", d, mem_din_v[d], wdata_v[d][gi*32 +: 32]);
            if (ewe == 4'b0000) q.push_back('{d: d, eg: eg, ed: ed, due: cyc + lat(d)});
        end else begin
            chk("mem_we_idle", d, 32'(mem_we_v[d]), 32'h0);
        end
        @(negedge clk);
    endtask

    // Pops the expected response whenever an instance raises rvalid
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rvalid_v[d] != 3'b000) begin
                    int hit;
                    hit = -1;
                    for (int i = 0; i < q.size(); i++) begin
                        if (hit < 0 && q[i].d == d) hit = i;
                    end
                    if (hit < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rvalid_unexpected dut%0d got %b expected none (cycle %0d)", d, rvalid_v[d], cyc);
                    end else begin
                        chk("rvalid", d, 32'(rvalid_v[d]), 32'(q[hit].eg));
                        chk("rdata", d, rdata_v[d], q[hit].ed);
                        chk("rlatency", d, 32'(cyc), 32'(q[hit].due));
                        q.delete(hit);
                    end
                end
            end
            begin
                int i;
                i = 0;
                while (i < q.size()) begin
                    if (q[i].due < cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL rvalid_missing dut%0d got none expected %b due %0d (cycle %0d)",
                                 q[i].d, q[i].eg, q[i].due, cyc);
                        q.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 256; k++) ram[d][k] = (d == 0 ? 32'h1000_0000 : 32'h2000_0000) + 32'(k);
            for (int k = 0; k < 4; k++) pipe[d][k] = 32'h0;
            req_v[d]   = 3'b111;
            we_v[d]    = '0;
            addr_v[d]  = '0;
            wdata_v[d] = '0;
        end
        ram[0][8'h10] = 32'hDEAD_BEEF;
        ram[0][8'h20] = 32'h1122_3344;
        rst = 1'b0;

        fork
            monitor();
        join_none

        // Reset state, with every master requesting
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt", d, 32'(gnt_v[d]), 32'h0);
            chk("rst_mem_en", d, 32'(mem_en_v[d]), 32'h0);
            chk("rst_mem_we", d, 32'(mem_we_v[d]), 32'h0);
            chk("rst_mem_addr", d, mem_addr_v[d], 32'h0);
            chk("rst_mem_din", d, mem_din_v[d], 32'h0);
            chk("rst_rvalid", d, 32'(rvalid_v[d]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        req_v[0] = 3'b000;
        req_v[1] = 3'b000;

        // Single read on the round-robin instance
        set_m(0, 0, 4'b0000, 32'h10, 32'h0);
        step(0, 3'b001, 3'b001, 32'hDEAD_BEEF);
        step(0, 3'b000, 3'b000, 32'h0);

        // All three requesting: rotation starts at master 1
        set_m(0, 0, 4'b0000, 32'h01, 32'h0);
        set_m(0, 1, 4'b0000, 32'h02, 32'h0);
        set_m(0, 2, 4'b0000, 32'h03, 32'h0);
        for (int r = 0; r < 2; r++) begin
            step(0, 3'b111, 3'b010, 32'h1000_0002);
            step(0, 3'b111, 3'b100, 32'h1000_0003);
            step(0, 3'b111, 3'b001, 32'h1000_0001);
        end
        // Sparse patterns exercising wrap-around
        step(0, 3'b101, 3'b100, 32'h1000_0003);
        step(0, 3'b101, 3'b001, 32'h1000_0001);
        step(0, 3'b110, 3'b010, 32'h1000_0002);
        step(0, 3'b000, 3'b000, 32'h0);

        // Byte-lane write then read-back of the same word
        set_m(0, 1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        step(0, 3'b010, 3'b010, 32'h0);
        set_m(0, 1, 4'b0000, 32'h20, 32'h0);
        step(0, 3'b010, 3'b010, 32'h11BB_33DD);
        step(0, 3'b000, 3'b000, 32'h0);

        // Reset with three reads in flight
        set_m(0, 0, 4'b0000, 32'h05, 32'h0);
        set_m(0, 1, 4'b0000, 32'h06, 32'h0);
        set_m(0, 2, 4'b0000, 32'h07, 32'h0);
        step(0, 3'b111, 3'b100, 32'h1000_0007);
        step(0, 3'b111, 3'b001, 32'h1000_0005);
        step(0, 3'b111, 3'b010, 32'h1000_0006);
        rst = 1'b0;
        q.delete();
        #1;
        chk("midrst_mem_en", 0, 32'(mem_en_v[0]), 32'h0);
        chk("midrst_rvalid", 0, 32'(rvalid_v[0]), 32'h0);
        chk("midrst_gnt", 0, 32'(gnt_v[0]), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 3'b110, 3'b010, 32'h1000_0006);
        step(0, 3'b000, 3'b000, 32'h0);

        // Fixed priority: master 0 wins while it requests
        set_m(1, 0, 4'b0000, 32'h30, 32'h0);
        set_m(1, 1, 4'b0000, 32'h31, 32'h0);
        set_m(1, 2, 4'b0000, 32'h32, 32'h0);
        for (int r = 0; r < 5; r++) step(1, 3'b011, 3'b001, 32'h2000_0030);
        step(1, 3'b010, 3'b010, 32'h2000_0031);
        step(1, 3'b111, 3'b001, 32'h2000_0030);
        step(1, 3'b110, 3'b010, 32'h2000_0031);
        step(1, 3'b000, 3'b000, 32'h0);

        // Back-to-back reads alternating masters on both latencies
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                set_m(d, k % 2, 4'b0000, 32'h40 + 32'(k), 32'h0);
                step(d, (k % 2) ? 3'b010 : 3'b001, (k % 2) ? 3'b010 : 3'b001,
                     (d == 0 ? 32'h1000_0040 : 32'h2000_0040) + 32'(k));
            end
            step(d, 3'b000, 3'b000, 32'h0);
        end

        repeat (8) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
